// File: rtl/pwm_fade_ctrl.sv
// Triangle "breathing" envelope sequencer for one PWM channel's duty value.
// Duty only changes on period-counter wrap, so the PWM never glitches mid-period.
module pwm_fade_ctrl #(
  parameter int PERIOD_W = 6,
  parameter int DUTY_W   = 7,
  parameter int MAX_DUTY = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DUTY_W-1:0] cfg_min,
  input  logic [DUTY_W-1:0] cfg_max,
  input  logic [CNT_W-1:0]  cfg_step,
  input  logic [CNT_W-1:0]  cfg_hold,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  // state    | meaning
  // S_IDLE   | waiting; config accepted; start arms the next tick
  // S_UP     | ramping duty towards max, one step per step-count ticks
  // S_HOLD_HI| parked at max for hold ticks
  // S_DOWN   | ramping duty towards min
  // S_HOLD_LO| parked at min for hold ticks, then loop or finish
  typedef enum logic [2:0] {
    S_IDLE, S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO
  } state_t;

  localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic                period_start_q, period_start_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [DUTY_W-1:0]   min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0]    step_q, step_d, hold_q, hold_d;
  logic                loop_q, loop_d;

  logic                tick, step_hit, hold_hit, env_end;
  logic [CNT_W-1:0]    cnt_inc;
  logic [DUTY_W-1:0]   duty_inc, duty_dec;

  assign tick     = &per_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign step_hit = (cnt_inc == step_q);
  // hold of 0 only reaches the hold states when min==max; leave after one tick
  assign hold_hit = (cnt_inc >= hold_q);
  assign duty_inc = duty_q + DUTY_W'(1);
  assign duty_dec = duty_q - DUTY_W'(1);

  always_comb begin
    per_d          = per_q + PERIOD_W'(1);
    period_start_d = (per_d == '0);
    state_d        = state_q;
    armed_d        = armed_q;
    cnt_d          = cnt_q;
    duty_d         = duty_q;
    done_d         = 1'b0;
    min_d          = min_q;
    max_d          = max_q;
    step_d         = step_q;
    hold_d         = hold_q;
    loop_d         = loop_q;
    env_end        = 1'b0;

    if (cfg_valid && cfg_ready_q) begin
      max_d  = (cfg_max > MAX_D) ? MAX_D : cfg_max;
      min_d  = (cfg_min > max_d) ? max_d : cfg_min;
      step_d = (cfg_step == '0) ? CNT_W'(1) : cfg_step;
      hold_d = cfg_hold;
      loop_d = cfg_loop;
    end

    if (stop) begin
      state_d = S_IDLE;
      armed_d = 1'b0;
      cnt_d   = '0;
      duty_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) armed_d = 1'b1;
          if (tick && armed_q) begin
            armed_d = 1'b0;
            duty_d  = min_q;
            cnt_d   = '0;
            state_d = (min_q == max_q) ? S_HOLD_HI : S_UP;
          end
        end
        S_UP: begin
          if (tick) begin
            if (step_hit) begin
              cnt_d  = '0;
              duty_d = duty_inc;
              if (duty_inc >= max_q) state_d = (hold_q == '0) ? S_DOWN : S_HOLD_HI;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HOLD_HI: begin
          if (tick) begin
            if (hold_hit) begin
              cnt_d   = '0;
              state_d = (duty_q == min_q) ? S_HOLD_LO : S_DOWN;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_DOWN: begin
          if (tick) begin
            if (step_hit) begin
              cnt_d  = '0;
              duty_d = duty_dec;
              if (duty_dec <= min_q) begin
                if (hold_q == '0) env_end = 1'b1;
                else              state_d = S_HOLD_LO;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HOLD_LO: begin
          if (tick) begin
            if (hold_hit) env_end = 1'b1;
            else          cnt_d   = cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (env_end) begin
        cnt_d = '0;
        if (loop_q) begin
          state_d = (min_q == max_q) ? S_HOLD_HI : S_UP;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    busy_d      = (state_d != S_IDLE);
    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      per_q          <= '0;
      period_start_q <= 1'b0;
      armed_q        <= 1'b0;
      cnt_q          <= '0;
      duty_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_ready_q    <= 1'b1;
      min_q          <= '0;
      max_q          <= MAX_D;
      step_q         <= CNT_W'(1);
      hold_q         <= '0;
      loop_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      per_q          <= per_d;
      period_start_q <= period_start_d;
      armed_q        <= armed_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cfg_ready_q    <= cfg_ready_d;
      min_q          <= min_d;
      max_q          <= max_d;
      step_q         <= step_d;
      hold_q         <= hold_d;
      loop_q         <= loop_d;
    end
  end

  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_ready    = cfg_ready_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: reset, one-shot ramp, step divider,
// clamping, degenerate min==max, abort, handshake and async reset.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [6:0]  cfg_min = 7'd0;
  logic [6:0]  cfg_max = 7'd0;
  logic [15:0] cfg_step = 16'd0;
  logic [15:0] cfg_hold = 16'd0;
  logic        cfg_loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [6:0]  duty;
  logic        period_start;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pwm_fade_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step),
    .cfg_hold(cfg_hold), .cfg_loop(cfg_loop),
    .start(start), .stop(stop),
    .duty(duty), .period_start(period_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // cyc counts edges since reset release; edge numbers divisible by 64 are ticks
  task automatic clk_step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_tick;
    do clk_step(); while (cyc % 64 != 0);
  endtask

  task automatic load_cfg(input logic [6:0] mn, input logic [6:0] mx,
                          input logic [15:0] st, input logic [15:0] hd,
                          input logic lp, input logic with_start);
    cfg_min = mn; cfg_max = mx; cfg_step = st; cfg_hold = hd; cfg_loop = lp;
    cfg_valid = 1'b1;
    start = with_start;
    clk_step();
    cfg_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    clk_step();
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
  endtask

  task automatic test_reset;
    logic exp_ps;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (duty !== 7'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got duty=%0d busy=%b rdy=%b done=%b ps=%b, expected 0 0 1 0 0",
               duty, busy, cfg_ready, done, period_start);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 130; c++) begin
      clk_step();
      exp_ps = (cyc % 64 == 0);
      n_checks++;
      if (period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL period_start cyc %0d: got %b expected %b", cyc, period_start, exp_ps);
      end
    end
  endtask

  task automatic test_one_shot;
    int exp_d[13] = '{0, 1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0};
    int dones = 0;
    wait_tick();
    load_cfg(7'd0, 7'd4, 16'd1, 16'd2, 1'b0, 1'b0);
    pulse_start();
    for (int k = 0; k < 13; k++) begin
      do begin
        clk_step();
        if (done === 1'b1) dones++;
      end while (cyc % 64 != 0);
      n_checks++;
      if (duty !== 7'(exp_d[k])) begin
        n_fail++;
        $display("FAIL one_shot_duty tick %0d: got %0d expected %0d", k, duty, exp_d[k]);
      end
      n_checks++;
      if (done !== (k == 12)) begin
        n_fail++;
        $display("FAIL one_shot_done tick %0d: got %b expected %b", k, done, (k == 12));
      end
    end
    n_checks++;
    if (dones != 1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL one_shot_end: got dones=%0d busy=%b rdy=%b expected 1 0 1", dones, busy, cfg_ready);
    end
    clk_step();
    n_checks++;
    if (done !== 1'b0 || duty !== 7'd0) begin
      n_fail++;
      $display("FAIL one_shot_after: got done=%b duty=%0d expected 0 0", done, duty);
    end
  endtask

  task automatic test_step_div;
    int seq4[4] = '{10, 11, 12, 11};
    int prev_exp;
    int now_exp;
    wait_tick();
    load_cfg(7'd10, 7'd12, 16'd3, 16'd0, 1'b1, 1'b0);
    pulse_start();
    wait_tick();
    n_checks++;
    if (duty !== 7'd10) begin
      n_fail++;
      $display("FAIL step_div_first: got %0d expected 10", duty);
    end
    for (int k = 1; k < 18; k++) begin
      prev_exp = seq4[((k - 1) / 3) % 4];
      now_exp  = seq4[(k / 3) % 4];
      for (int c = 1; c <= 64; c++) begin
        clk_step();
        n_checks++;
        if (c < 64 && (duty !== 7'(prev_exp) || busy !== 1'b1)) begin
          n_fail++;
          $display("FAIL step_div_offtick tick %0d cyc %0d: got duty=%0d busy=%b expected %0d 1",
                   k, c, duty, busy, prev_exp);
        end else if (c == 64 && duty !== 7'(now_exp)) begin
          n_fail++;
          $display("FAIL step_div_tick %0d: got %0d expected %0d", k, duty, now_exp);
        end
      end
    end
    pulse_stop();
    n_checks++;
    if (duty !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL step_div_stop: got duty=%0d busy=%b expected 0 0", duty, busy);
    end
  endtask

  task automatic test_clamp;
    wait_tick();
    load_cfg(7'd90, 7'd100, 16'd1, 16'd2, 1'b1, 1'b0);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      wait_tick();
      n_checks++;
      if (duty !== 7'd64 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL clamp tick %0d: got duty=%0d busy=%b done=%b expected 64 1 0", k, duty, busy, done);
      end
    end
    pulse_stop();
  endtask

  task automatic test_degenerate;
    int dones = 0;
    wait_tick();
    load_cfg(7'd5, 7'd5, 16'd1, 16'd3, 1'b0, 1'b0);
    pulse_start();
    wait_tick();
    n_checks++;
    if (duty !== 7'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL degen_start: got duty=%0d busy=%b expected 5 1", duty, busy);
    end
    for (int k = 1; k <= 6; k++) begin
      do begin
        clk_step();
        if (done === 1'b1) dones++;
      end while (cyc % 64 != 0);
      n_checks++;
      if (duty !== 7'd5 || done !== (k == 6)) begin
        n_fail++;
        $display("FAIL degen tick %0d: got duty=%0d done=%b expected 5 %b", k, duty, done, (k == 6));
      end
    end
    n_checks++;
    if (dones != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL degen_end: got dones=%0d busy=%b expected 1 0", dones, busy);
    end
  endtask

  task automatic test_abort;
    int dones = 0;
    wait_tick();
    load_cfg(7'd0, 7'd10, 16'd1, 16'd0, 1'b1, 1'b0);
    pulse_start();
    repeat (3) wait_tick();
    n_checks++;
    if (duty !== 7'd2) begin
      n_fail++;
      $display("FAIL abort_pre: got %0d expected 2", duty);
    end
    pulse_stop();
    n_checks++;
    if (duty !== 7'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: got duty=%0d busy=%b rdy=%b done=%b expected 0 0 1 0",
               duty, busy, cfg_ready, done);
    end
    for (int c = 0; c < 140; c++) begin
      clk_step();
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (duty !== 7'd0 || busy !== 1'b0 || dones != 0) begin
      n_fail++;
      $display("FAIL abort_after: got duty=%0d busy=%b dones=%0d expected 0 0 0", duty, busy, dones);
    end
    start = 1'b1;
    stop = 1'b1;
    clk_step();
    start = 1'b0;
    stop = 1'b0;
    repeat (2) wait_tick();
    n_checks++;
    if (busy !== 1'b0 || duty !== 7'd0) begin
      n_fail++;
      $display("FAIL start_stop_same: got busy=%b duty=%0d expected 0 0", busy, duty);
    end
    pulse_start();
    pulse_stop();
    repeat (2) wait_tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_clears_armed: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_handshake;
    int exp_a[7] = '{2, 3, 3, 2, 1, 0, 0};
    int exp_b[5] = '{0, 1, 2, 3, 3};
    int dones = 0;
    wait_tick();
    load_cfg(7'd0, 7'd3, 16'd1, 16'd1, 1'b0, 1'b1);
    wait_tick();
    wait_tick();
    n_checks++;
    if (duty !== 7'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_ramp: got duty=%0d busy=%b expected 1 1", duty, busy);
    end
    cfg_min = 7'd20; cfg_max = 7'd60; cfg_step = 16'd5; cfg_hold = 16'd9; cfg_loop = 1'b1;
    cfg_valid = 1'b1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_ready_busy: got %b expected 0", cfg_ready);
    end
    clk_step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      do begin
        clk_step();
        if (done === 1'b1) dones++;
      end while (cyc % 64 != 0);
      n_checks++;
      if (duty !== 7'(exp_a[k]) || done !== (k == 6)) begin
        n_fail++;
        $display("FAIL hs_env tick %0d: got duty=%0d done=%b expected %0d %b",
                 k + 2, duty, done, exp_a[k], (k == 6));
      end
    end
    n_checks++;
    if (dones != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_end: got dones=%0d busy=%b expected 1 0", dones, busy);
    end
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      n_checks++;
      if (duty !== 7'(exp_b[k])) begin
        n_fail++;
        $display("FAIL hs_cfg_kept tick %0d: got %0d expected %0d", k, duty, exp_b[k]);
      end
    end
    pulse_stop();
  endtask

  task automatic test_async_reset;
    wait_tick();
    pulse_start();
    repeat (3) wait_tick();
    n_checks++;
    if (duty !== 7'd2) begin
      n_fail++;
      $display("FAIL areset_pre: got %0d expected 2", duty);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (duty !== 7'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outputs: got duty=%0d busy=%b rdy=%b done=%b ps=%b expected 0 0 1 0 0",
               duty, busy, cfg_ready, done, period_start);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      n_checks++;
      if (duty !== 7'(k) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL default_cfg tick %0d: got duty=%0d busy=%b expected %0d 1", k, duty, busy, k);
      end
    end
    pulse_stop();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_step_div();
    test_clamp();
    test_degenerate();
    test_abort();
    test_handshake();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Envelope sequencer that drives the 7-bit duty value of one PWM channel, producing triangle "breathing" fades: ramp up, hold high, ramp down, hold low.
- Runs its own PWM-period counter and changes the duty value only at period boundaries, so the driven PWM never sees a mid-period glitch.
- Configured through a valid/ready load port and controlled by start/stop strobes.
- One instance per LED channel.

Parameters:
- PERIOD_W, 6, width of the internal period counter; one PWM period is 2^PERIOD_W clk cycles.
- DUTY_W, 7, width of the duty output and of cfg_min/cfg_max.
- MAX_DUTY, 64, upper clamp for the duty value (full on for a 64-cycle period).
- CNT_W, 16, width of the step and hold period counts.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cfg_valid  in  1  configuration word present.
- cfg_ready  out  1  high only in IDLE; a config is captured when cfg_valid && cfg_ready.
- cfg_min  in  DUTY_W  lowest duty of the envelope.
- cfg_max  in  DUTY_W  highest duty of the envelope.
- cfg_step  in  CNT_W  PWM periods per duty increment or decrement; 0 is treated as 1.
- cfg_hold  in  CNT_W  PWM periods spent at each extreme; 0 means no hold.
- cfg_loop  in  1  1 = repeat forever, 0 = one envelope then stop.
- start  in  1  one-cycle strobe; begins the envelope; ignored unless IDLE.
- stop  in  1  one-cycle strobe; abort from any state.
- duty  out  DUTY_W  registered duty value for the PWM.
- period_start  out  1  registered; high for the one cycle in which the period counter is 0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a one-shot envelope completes.

Behaviour:
- Reset values: duty=0, busy=0, done=0, period_start=0, period counter=0, state IDLE, step/hold counters=0.
- Reset values of the config registers: min=0, max=MAX_DUTY, step=1, hold=0, loop=1.
- Period counter:
  - Free-runs 0..2^PERIOD_W-1 from reset, whatever the FSM state.
  - tick is the edge on which the counter is at its maximum and wraps to 0.
  - All duty changes and all step/hold counting happen only on tick edges.
- Config capture:
  - In IDLE, cfg_valid latches all cfg_* fields.
  - cfg_max above MAX_DUTY is clamped to MAX_DUTY.
  - If cfg_min > cfg_max after clamping, min is set equal to max.
- States and transitions:
  - IDLE: start sets an armed flag. On the next tick: duty<=min, step counter cleared. Go to UP, or straight to HOLD_HI if min==max.
  - UP: each tick increments the step counter. When it reaches the step count: duty+1, counter cleared. If the new duty equals max, go to HOLD_HI, or straight to DOWN if hold==0.
  - HOLD_HI: counts ticks. On the tick where the count reaches hold: go to DOWN with the step counter cleared, duty unchanged.
  - DOWN: mirror of UP using duty-1. On reaching min: go to HOLD_LO, or straight to the end-of-envelope action if hold==0.
  - HOLD_LO, end-of-envelope action:
    - With loop=1: go to UP, or HOLD_HI if min==max.
    - With loop=0: go to IDLE, pulse done for one cycle; duty stays at min.
- stop:
  - Takes effect on the next edge regardless of tick: state IDLE, duty=0, armed flag and counters cleared, no done pulse.
  - If stop and start arrive in the same cycle, stop wins.
  - stop in IDLE clears a pending armed start.
- A config and start in the same IDLE cycle: the config is captured and the envelope uses the new values.
- cfg_valid outside IDLE: not accepted (cfg_ready=0); the held config is unchanged.
- Duty arithmetic: unsigned and never wraps. It stays within [min,max] and never exceeds MAX_DUTY.
- Reset mid-envelope: all outputs go to their reset values immediately (asynchronous).

Test Plan:
- Reset: hold rst_n low mid-count -> duty=0, busy=0, cfg_ready=1. After release, period_start is high every 64 cycles (PERIOD_W=6).
- One-shot ramp: min=0, max=4, step=1, hold=2, loop=0, then start -> duty at successive ticks 0,1,2,3,4,4,4,3,2,1,0,0,0. done pulses once, on the 13th tick edge. busy then falls and cfg_ready=1.
- Step divider: step=3, min=10, max=12, hold=0, loop=1 -> duty changes every 3 ticks: 10,11,12,11,10,11,... Never changes off a tick edge.
- Clamp and degenerate config: max=100, min=90 -> duty is held at 64 permanently in HOLD_HI/HOLD_LO cycling. min=max=5 with loop=0 -> duty=5 then done after 2*hold ticks.
- Abort: stop mid-UP at duty=2 -> next cycle duty=0, busy=0, no done pulse. Start and stop in the same cycle -> stays IDLE.
- Handshake: cfg_valid while busy -> cfg_ready=0 and the envelope is unaffected. cfg_valid with start in IDLE -> the new max is used on the first ramp.
